fpmul_sequencer: RTL and testbench
==================================

# fpmul_sequencer

Consumer end of the operand-entry interface on the board datapath. Holds `loaddata` high while the peripherals unit collects operands A and B, captures both 32-bit operands when `inputdata_ready` rises, and computes their IEEE-754 single-precision product with an iterative 24-cycle shift-add mantissa multiplier. It then returns the result on `dataR` and drops `loaddata`, which switches the peripherals unit to result display.

## Interface
- `QNAN`, default 32'h7FC00000: canonical quiet-NaN result code.
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `inputdata_ready`  in  1  high when both operands are entered (or when `loaddata` is low).
- `dataA`  in  32  operand A, single-precision.
- `dataB`  in  32  operand B, single-precision.
- `loaddata`  out  1  high requests operand entry; low selects result display.
- `dataR`  out  32  registered product.
- `busy`  out  1  high from capture until the result is written.
- `done`  out  1  high while in SHOW.
- `flags`  out  3  {nan, inf, zero} classification of `dataR`, registered with it.

## Operation
- States: LOAD → UNPACK → MUL (24 cycles) → NORM → ROUND → SHOW.
- LOAD: `loaddata`=1. On a clock edge with `inputdata_ready`=1, latch `dataA`/`dataB` into internal registers and go to UNPACK. `inputdata_ready` is ignored in every other state.
- UNPACK: split each operand into sign, exponent, and 24-bit mantissa (hidden bit = 1 for exp≠0).
  - An operand with exp=0 is zero; denormals flush to zero.
  - Classify specials:
    - any NaN → QNAN
    - inf×0 → QNAN
    - inf×finite → ±inf
    - 0×finite → ±0
  - Start the multiplier.
- MUL: shift-add, one multiplier bit per cycle, 48-bit product P.
- NORM:
  - If P[47]=1: mant=P[46:24], guard=P[23], sticky=|P[22:0], e=ea+eb−126.
  - Otherwise: mant=P[45:23], guard=P[22], sticky=|P[21:0], e=ea+eb−127.
  - e is held as a 10-bit signed value.
- ROUND: round to nearest, ties to even.
  - Mantissa carry-out → mant=0, e+1.
  - e≥255 → ±inf (0x7F800000 | sign).
  - e≤0 → ±0.
  - Special-case results override the arithmetic result here.
  - Write `dataR` and `flags`, then go to SHOW.
- Sign = sa XOR sb for all results except QNAN, whose sign bit is 0.
- SHOW: `loaddata`=0, `done`=1, `dataR` held. SHOW is terminal until `reset`.

## Timing
- Reset values:
  - state=LOAD
  - `loaddata`=1
  - `dataR`=0
  - `flags`=3'b000
  - `busy`=0
  - `done`=0
  - internal registers=0
- Capture edge = edge 0. Then UNPACK at edge 1, MUL at edges 2–25, NORM at edge 26, ROUND at edge 27.
- `dataR`, `flags`, and `done`=1 are visible after edge 27. `loaddata` falls at that same edge.
- Latency is fixed at 27 cycles for all inputs, specials included.
- `busy`=1 from after edge 0 until after edge 27.
- `dataR` holds its previous value (0 after reset) until edge 27.
- `inputdata_ready` held low: the block stays in LOAD indefinitely with `busy`=0.
- `reset` asserted mid-operation: all outputs return to reset values immediately (asynchronous); any partial result is discarded.
- `loaddata`, `busy`, and `done` are decoded from registered state with no combinational path from inputs.

## Structure
- Shared package `fpmul_pkg`:
  - state enum `fpmul_state_t`
  - `BIAS`=127, `EXP_W`=8, `MANT_W`=23, `QNAN`, `PINF`=32'h7F800000
  - flag bit indices
- Sub-module `seq_mult24`:
  - ports: 24×24 unsigned shift-add multiplier with `start`/`done`, 48-bit product.
  - exactly 24 cycles from `start` to `done`.
  - uses the same `clk` and active-low `reset`.
- The top level contains the FSM, unpack/special-case logic, normalize, and round/pack.

## Test plan
- 3F800000 × 40000000 (1.0×2.0) → `dataR`=40000000, `flags`=000, `done`=1 and `loaddata`=0 exactly 27 cycles after capture.
- 3FC00000 × 3FC00000 (1.5×1.5) → 40100000. 3F800001 × 3F800001 → 3F800002 (below half, rounds down).
- 7F800000 × 00000000 → 7FC00000, `flags`=100. 7FC00001 × 3F800000 → 7FC00000. FF800000 × 40000000 → FF800000, `flags`=010.
- 7F000000 × 7F000000 → 7F800000 (overflow), `flags`=010. 00800000 × 00800000 → 00000000 (underflow), `flags`=001. 80000000 × 3F800000 → 80000000.
- Hold `inputdata_ready`=0 for 100 cycles → no capture, `busy`=0, `loaddata`=1, `dataR`=0. Change `dataA` after edge 0 → result unaffected.
- Assert `reset` low at cycle 10 of MUL → `dataR`=0, `loaddata`=1, `busy`=0 immediately. A fresh operand pair after release yields the correct product.

Source files
------------

// File: rtl/fpmul_pkg.sv
// fpmul_pkg: shared state type, IEEE-754 constants and result classification
// for the single-precision multiply sequencer.
package fpmul_pkg;
   typedef enum logic [2:0] {S_LOAD, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_SHOW} fpmul_state_t;
   typedef enum logic [1:0] {SP_NONE, SP_QNAN, SP_INF, SP_ZERO} special_t;
   localparam int BIAS = 127;
   localparam int EXP_W = 8;
   localparam int MANT_W = 23;
   localparam logic [31:0] QNAN = 32'h7FC00000;
   localparam logic [31:0] PINF = 32'h7F800000;
   localparam int FLAG_NAN = 2;
   localparam int FLAG_INF = 1;
   localparam int FLAG_ZERO = 0;
   function automatic logic [2:0] classify(input logic [31:0] r);
      logic [2:0] f;
      f = '0;
      f[FLAG_NAN] = (&r[30:23]) && (|r[22:0]);
      f[FLAG_INF] = (&r[30:23]) && !(|r[22:0]);
      f[FLAG_ZERO] = !(|r[30:0]);
      return f;
   endfunction
endpackage

// File: rtl/fpmul_sequencer_seq_mult24.sv
// seq_mult24: 24x24 unsigned shift-add multiplier; the first partial product
// is taken on the start edge so done rises exactly 24 cycles after start.
module seq_mult24 (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [23:0] a,
   input  logic [23:0] b,
   output logic [47:0] p,
   output logic        done
);
   logic [47:0] mc;
   logic [23:0] mp;
   logic [4:0]  cnt;
   logic        run;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p    <= '0;
         mc   <= '0;
         mp   <= '0;
         cnt  <= '0;
         run  <= 1'b0;
         done <= 1'b0;
      end else if (start) begin
         p    <= b[0] ? {24'b0, a} : 48'b0;
         mc   <= {23'b0, a, 1'b0};
         mp   <= {1'b0, b[23:1]};
         cnt  <= 5'd23;
         run  <= 1'b1;
         done <= 1'b0;
      end else if (run) begin
         p    <= mp[0] ? p + mc : p;
         mc   <= mc << 1;
         mp   <= mp >> 1;
         cnt  <= cnt - 5'd1;
         run  <= cnt != 5'd1;
         done <= cnt == 5'd1;
      end else begin
         done <= 1'b0;
      end
   end
endmodule

// File: rtl/fpmul_sequencer.sv
// fpmul_sequencer: captures two single-precision operands, multiplies them with
// a fixed 27-cycle latency and presents the rounded product until reset.
module fpmul_sequencer
   import fpmul_pkg::*;
#(
   parameter logic [31:0] QNAN = fpmul_pkg::QNAN
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inputdata_ready,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   output logic        loaddata,
   output logic [31:0] dataR,
   output logic        busy,
   output logic        done,
   output logic [2:0]  flags
);
   fpmul_state_t      state;
   special_t          spec, spec_d;
   logic [31:0]       ra, rb, res;
   logic              sign, guard, sticky, rnd_up, mdone;
   logic [EXP_W-1:0]  ea, eb;
   logic [MANT_W-1:0] mant;
   logic [MANT_W:0]   mant_r;
   logic signed [9:0] e, e_r;
   logic [47:0]       p;
   logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   assign a_zero = ra[30:23] == '0;
   assign b_zero = rb[30:23] == '0;
   assign a_inf  = (&ra[30:23]) && !(|ra[22:0]);
   assign b_inf  = (&rb[30:23]) && !(|rb[22:0]);
   assign a_nan  = (&ra[30:23]) && (|ra[22:0]);
   assign b_nan  = (&rb[30:23]) && (|rb[22:0]);
   assign spec_d = (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) ? SP_QNAN :
                   (a_inf || b_inf) ? SP_INF : (a_zero || b_zero) ? SP_ZERO : SP_NONE;
   seq_mult24 u_mult (
      .clk  (clk),
      .reset(reset),
      .start(state == S_UNPACK),
      .a    ({!a_zero, ra[22:0]}),
      .b    ({!b_zero, rb[22:0]}),
      .p    (p),
      .done (mdone)
   );
   // Carry out of the rounded mantissa leaves the fraction bits at zero, so only e moves.
   assign rnd_up = guard && (sticky || mant[0]);
   assign mant_r = {1'b0, mant} + {{MANT_W{1'b0}}, rnd_up};
   assign e_r    = e + $signed({9'b0, mant_r[MANT_W]});
   assign res = spec == SP_QNAN ? QNAN :
                (spec == SP_INF || e_r >= 10'sd255) ? (PINF | {sign, 31'b0}) :
                (spec == SP_ZERO || e_r <= 10'sd0) ? {sign, 31'b0} :
                {sign, e_r[EXP_W-1:0], mant_r[MANT_W-1:0]};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_LOAD;
         loaddata <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         dataR    <= '0;
         flags    <= '0;
         ra       <= '0;
         rb       <= '0;
         sign     <= 1'b0;
         ea       <= '0;
         eb       <= '0;
         spec     <= SP_NONE;
         mant     <= '0;
         guard    <= 1'b0;
         sticky   <= 1'b0;
         e        <= '0;
      end else begin
         case (state)
            S_LOAD: if (inputdata_ready) begin
               ra    <= dataA;
               rb    <= dataB;
               busy  <= 1'b1;
               state <= S_UNPACK;
            end
            S_UNPACK: begin
               sign  <= ra[31] ^ rb[31];
               ea    <= ra[30:23];
               eb    <= rb[30:23];
               spec  <= spec_d;
               state <= S_MUL;
            end
            S_MUL: if (mdone) state <= S_NORM;
            S_NORM: begin
               mant   <= p[47] ? p[46:24] : p[45:23];
               guard  <= p[47] ? p[23] : p[22];
               sticky <= p[47] ? |p[22:0] : |p[21:0];
               e      <= $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'(p[47] ? BIAS - 1 : BIAS);
               state  <= S_ROUND;
            end
            S_ROUND: begin
               dataR    <= res;
               flags    <= classify(res);
               loaddata <= 1'b0;
               busy     <= 1'b0;
               done     <= 1'b1;
               state    <= S_SHOW;
            end
            S_SHOW: state <= S_SHOW;
            default: state <= S_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_fpmul_sequencer.sv
// tb_fpmul_sequencer: directed vector table plus hand sequences for idle hold,
// operand change after capture and reset in the middle of a multiply.
module tb_fpmul_sequencer;
   logic        clk = 1'b0;
   logic        reset, inputdata_ready, loaddata, busy, done;
   logic [31:0] dataA, dataB, dataR;
   logic [2:0]  flags;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic [2:0]  f;
      logic        chg;
   } vec_t;
   vec_t v[10];

   fpmul_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .inputdata_ready(inputdata_ready),
      .dataA          (dataA),
      .dataB          (dataB),
      .loaddata       (loaddata),
      .dataR          (dataR),
      .busy           (busy),
      .done           (done),
      .flags          (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
   endtask

   task automatic do_op(input int i, input vec_t t);
      @(negedge clk);
      dataA = t.a;
      dataB = t.b;
      inputdata_ready = 1'b1;
      @(posedge clk);
      #1 chk($sformatf("v%0d_busy_after_capture", i), busy, 1);
      @(negedge clk);
      inputdata_ready = 1'b0;
      if (t.chg) dataA = ~t.a;
      repeat (26) @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_edge26", i), done, 0);
      chk($sformatf("v%0d_loaddata_edge26", i), loaddata, 1);
      chk($sformatf("v%0d_dataR_held_edge26", i), dataR, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_edge27", i), done, 1);
      chk($sformatf("v%0d_loaddata_edge27", i), loaddata, 0);
      chk($sformatf("v%0d_busy_edge27", i), busy, 0);
      chk($sformatf("v%0d_dataR", i), dataR, t.r);
      chk($sformatf("v%0d_flags", i), {29'b0, flags}, {29'b0, t.f});
   endtask

   initial begin
      v[0] = '{32'h3F800000, 32'h40000000, 32'h40000000, 3'b000, 1'b0};
      v[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, 1'b0};
      v[2] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 3'b000, 1'b0};
      v[3] = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100, 1'b0};
      v[4] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 1'b0};
      v[5] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 3'b010, 1'b0};
      v[6] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b010, 1'b0};
      v[7] = '{32'h00800000, 32'h00800000, 32'h00000000, 3'b001, 1'b0};
      v[8] = '{32'h80000000, 32'h3F800000, 32'h80000000, 3'b001, 1'b0};
      v[9] = '{32'h40400000, 32'h3FC00000, 32'h40900000, 3'b000, 1'b1};
      reset = 1'b0;
      inputdata_ready = 1'b0;
      dataA = '0;
      dataB = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_loaddata", loaddata, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dataR", dataR, 0);
      chk("rst_flags", {29'b0, flags}, 0);
      @(negedge clk) reset = 1'b1;
      dataA = 32'h3F800000;
      dataB = 32'h40000000;
      repeat (100) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_loaddata", loaddata, 1);
      chk("idle_dataR", dataR, 0);
      chk("idle_done", done, 0);
      for (int i = 0; i < 10; i++) begin
         do_reset();
         do_op(i, v[i]);
      end
      // Result of v[9] is still displayed; a capture mid-multiply then gets aborted.
      chk("show_before_abort", dataR, 32'h40900000);
      do_reset();
      @(negedge clk);
      dataA = 32'h3F800000;
      dataB = 32'h40400000;
      inputdata_ready = 1'b1;
      @(posedge clk);
      @(negedge clk) inputdata_ready = 1'b0;
      repeat (11) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_dataR", dataR, 0);
      chk("abort_loaddata", loaddata, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      @(negedge clk) reset = 1'b1;
      do_op(11, v[1]);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
